// File: rtl/decoder_scan_ctrl_if.sv
// decoder_scan_ctrl_if: scan-enable controls in, '139 select/enable and frame marker out.
interface decoder_scan_ctrl_if;
    logic       en;
    logic       hold;
    logic [3:0] mask;
    logic       g_n;
    logic       a;
    logic       b;
    logic [1:0] chan;
    logic       frame_start;
    modport master (output en, hold, mask, input g_n, a, b, chan, frame_start);
    modport slave (input en, hold, mask, output g_n, a, b, chan, frame_start);
endinterface

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: scans '139 channels 0..3 with blank-before-drive so selects move only while g_n=1.
module decoder_scan_ctrl #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder_scan_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;
    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [1:0]           chan_q;
    logic                 g_n_q;
    logic                 frame_q;
    logic                 first_q;
    logic [1:0]           low_chan;
    logic [1:0]           next_chan;
    always_comb begin
        low_chan = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (bus.mask[i]) low_chan = 2'(i);
        next_chan = chan_q;
        for (int k = 3; k >= 1; k--)
            if (bus.mask[chan_q + 2'(k)]) next_chan = chan_q + 2'(k);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chan_q  <= 2'd0;
            g_n_q   <= 1'b1;
            frame_q <= 1'b0;
            first_q <= 1'b0;
        end else if (!bus.en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_n_q   <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            case (state_q)
                IDLE: if (|bus.mask) begin
                    chan_q  <= low_chan;
                    first_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= BLANK;
                end
                BLANK: if (cnt_q == CNT_WIDTH'(BLANK_CYCLES - 1)) begin
                    cnt_q   <= '0;
                    g_n_q   <= 1'b0;
                    frame_q <= first_q;
                    first_q <= 1'b0;
                    state_q <= DRIVE;
                end else begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
                // first_q doubles as "frame pending" so a wrap is flagged on the next drive
                DRIVE: if (!bus.hold) begin
                    if (cnt_q == CNT_WIDTH'(DWELL_CYCLES - 1)) begin
                        cnt_q <= '0;
                        g_n_q <= 1'b1;
                        if (|bus.mask) begin
                            chan_q  <= next_chan;
                            first_q <= (next_chan <= chan_q);
                            state_q <= BLANK;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    g_n_q   <= 1'b1;
                end
            endcase
        end
    end
    assign bus.g_n         = g_n_q;
    assign bus.a           = chan_q[0];
    assign bus.b           = chan_q[1];
    assign bus.chan        = chan_q;
    assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: scoreboard of expected dwells (channel, frame marker, blank and dwell lengths).
module tb_decoder_scan_ctrl;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    decoder_scan_ctrl_if bus();
    decoder_scan_ctrl #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {int chan; int frame; int blank; int len;} rec_t;
    rec_t sb[$];
    rec_t r;
    int checks = 0;
    int errors = 0;
    int prev_g = 1, prev_ab = 0, hcnt = 0, lcnt = 0;
    int cur_chan = 0, cur_frame = 0, cur_blank = 0;
    logic [3:0] y_n;
    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask
    function automatic logic [3:0] dec139(logic g, logic bb, logic aa);
        dec139 = 4'hF;
        if (!g) dec139[{bb, aa}] = 1'b0;
    endfunction
    // expected dwells for a run of n channels with a fixed mask
    task automatic push_run(logic [3:0] m, int n, int hold_idx, int hold_len, bit trunc_last);
        int c = 0, nc;
        int wrap = 1;
        for (int i = 3; i >= 0; i--) if (m[i]) c = i;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{c, wrap, (i == 0) ? -1 : BLANK,
                           (trunc_last && i == n - 1) ? -1 : DWELL + ((i == hold_idx) ? hold_len : 0)});
            nc = c;
            for (int k = 4; k >= 1; k--) if (m[(c + k) % 4]) nc = (c + k) % 4;
            wrap = (nc <= c) ? 1 : 0;
            c = nc;
        end
    endtask
    always @(negedge clk) begin
        y_n = dec139(bus.g_n, bus.b, bus.a);
        check("y_n", int'(y_n), bus.g_n ? 15 : (15 ^ (1 << bus.chan)));
        if (!bus.g_n && prev_g == 0) check("ab_stable", int'({bus.b, bus.a}), prev_ab);
        if (bus.frame_start && !(!bus.g_n && prev_g == 1)) check("frame_pos", 1, 0);
        if (!bus.g_n && prev_g == 1) begin
            cur_chan = bus.chan;
            cur_frame = bus.frame_start;
            cur_blank = hcnt;
            lcnt = 1;
        end else if (!bus.g_n) begin
            lcnt++;
        end else if (prev_g == 0) begin
            if (sb.size() == 0) check("unexpected_dwell", cur_chan, -1);
            else begin
                r = sb.pop_front();
                check("chan", cur_chan, r.chan);
                check("frame_start", cur_frame, r.frame);
                if (r.blank >= 0) check("blank_len", cur_blank, r.blank);
                if (r.len >= 0) check("dwell_len", lcnt, r.len);
            end
            hcnt = 1;
        end else begin
            hcnt++;
        end
        prev_g = bus.g_n;
        prev_ab = {bus.b, bus.a};
    end
    task automatic drive(bit e, logic [3:0] m);
        @(posedge clk);
        #1;
        bus.en = e;
        bus.mask = m;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("scoreboard_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask
    task automatic wait_low(int c);
        bit found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (!bus.g_n && bus.chan == c) found = 1;
        end
        if (!found) check("wait_drive_timeout", c, -1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end
    initial begin
        logic [3:0] m;
        int n;
        bus.en = 1'b1;
        bus.hold = 1'b0;
        bus.mask = 4'hF;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'({bus.g_n, bus.a, bus.b, bus.chan, bus.frame_start}), 32);
        end
        push_run(4'hF, 5, -1, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done();
        drive(0, 4'hF);
        push_run(4'b1010, 4, -1, 0, 0);
        drive(1, 4'b1010);
        wait_done();
        drive(0, 4'b1010);
        push_run(4'b0100, 3, -1, 0, 0);
        drive(1, 4'b0100);
        wait_done();
        drive(0, 4'b0100);
        push_run(4'hF, 4, 2, 10, 0);
        drive(1, 4'hF);
        wait_low(2);
        @(posedge clk);
        #1 bus.hold = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.hold = 1'b0;
        wait_done();
        drive(0, 4'hF);
        push_run(4'hF, 2, -1, 0, 1);
        drive(1, 4'hF);
        wait_low(1);
        drive(0, 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("en_off_g_n", int'(bus.g_n), 1);
        check("en_off_chan", int'(bus.chan), 1);
        wait_done();
        push_run(4'b0110, 2, -1, 0, 0);
        drive(1, 4'b0110);
        wait_done();
        drive(0, 4'b0110);
        push_run(4'hF, 2, -1, 0, 0);
        drive(1, 4'hF);
        wait_low(1);
        drive(1, 4'h0);
        wait_done();
        repeat (20) @(negedge clk);
        check("mask_empty_idle", int'(bus.g_n), 1);
        drive(0, 4'h0);
        push_run(4'hF, 4, -1, 0, 1);
        drive(1, 4'hF);
        wait_low(3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_drive", int'({bus.g_n, bus.a, bus.b, bus.chan, bus.frame_start}), 32);
        wait_done();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int it = 0; it < 8; it++) begin
            m = 4'($urandom_range(1, 15));
            n = $urandom_range(2, 7);
            push_run(m, n, -1, 0, 0);
            drive(1, m);
            wait_done();
            drive(0, m);
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
